// File: rtl/cstrip_pkg.sv
// Shared definitions for the comment stripper: state encoding and the
// character codes the scanner reacts to.
package cstrip_pkg;

  typedef enum logic [2:0] {
    CODE      = 3'd0,
    BLK_OPEN  = 3'd1,
    BLK       = 3'd2,
    BLK_CLOSE = 3'd3,
    LINE      = 3'd4
  } state_t;

  localparam logic [7:0] SLASH = 8'h2F;
  localparam logic [7:0] STAR  = 8'h2A;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/comment_strip_if.sv
// Byte-stream bundle between a source and the comment stripper. No handshake:
// one byte flows in and one cleaned byte flows out on every clock.
interface comment_strip_if;
  import cstrip_pkg::*;

  logic [7:0] in;
  logic [7:0] out;
  logic       in_cmt;
  logic [7:0] cmt_cnt;
  state_t     dbg_state;

  modport master (output in, input out, input in_cmt, input cmt_cnt, input dbg_state);
  modport slave  (input in, output out, output in_cmt, output cmt_cnt, output dbg_state);
endinterface

// File: rtl/comment_strip.sv
// Removes C block and line comments from a raw byte stream, replacing every
// removed byte and every CR/LF with a space; output lags input by one cycle.
module comment_strip
  import cstrip_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  comment_strip_if.slave  bus
);

  state_t     r_state;
  logic [7:0] r_prev;
  logic [7:0] r_out;
  logic       r_in_cmt;
  logic [7:0] r_cmt_cnt;

  logic       w_open_blk;
  logic       w_open_line;
  logic       w_close_blk;
  logic       w_line_end;
  logic [7:0] w_cnt_inc;

  function automatic logic [7:0] map_byte(input logic [7:0] c);
    return ((c == LF) || (c == CR)) ? SPACE : c;
  endfunction

  // r_prev is the byte being decided; bus.in is its one-byte lookahead.
  assign w_open_blk  = (r_prev == SLASH) && (bus.in == STAR);
  assign w_open_line = (r_prev == SLASH) && (bus.in == SLASH);
  assign w_close_blk = (r_prev == STAR)  && (bus.in == SLASH);
  assign w_line_end  = (r_prev == LF);
  assign w_cnt_inc   = (r_cmt_cnt == CNT_MAX) ? CNT_MAX : r_cmt_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CODE;
      r_prev    <= SPACE;
      r_out     <= SPACE;
      r_in_cmt  <= 1'b0;
      r_cmt_cnt <= 8'd0;
    end else begin
      r_prev   <= bus.in;
      r_out    <= SPACE;
      r_in_cmt <= 1'b1;
      case (r_state)
        CODE: begin
          if (w_open_blk) begin
            r_state <= BLK_OPEN;
          end else if (w_open_line) begin
            r_state <= LINE;
          end else begin
            r_out    <= map_byte(r_prev);
            r_in_cmt <= 1'b0;
          end
        end
        // The opener's star is consumed here so "/*/" cannot close.
        BLK_OPEN: r_state <= BLK;
        BLK: begin
          if (w_close_blk) r_state <= BLK_CLOSE;
        end
        BLK_CLOSE: begin
          r_cmt_cnt <= w_cnt_inc;
          r_state   <= CODE;
        end
        LINE: begin
          if (w_line_end) begin
            r_cmt_cnt <= w_cnt_inc;
            r_state   <= CODE;
          end
        end
        default: r_state <= CODE;
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.in_cmt    = r_in_cmt;
  assign bus.cmt_cnt   = r_cmt_cnt;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_comment_strip.sv
// Self-checking bench for comment_strip: directed strings plus random streams
// compared against a whole-string reference scan of the comment rules.
module tb_comment_strip;
  import cstrip_pkg::*;

  logic clk;
  logic reset;
  comment_strip_if bus();

  comment_strip dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic       exp_cmt_q[$];
  logic [7:0] exp_cnt_q[$];
  logic [7:0] got_q[$];
  int         cmt_seen;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Scans the whole stimulus: finds each block and line comment span, marks
  // its bytes as comment, and records at which byte each comment completes.
  task automatic build_model();
    int n;
    int i;
    int j;
    int cnt;
    bit found;
    bit mark[$];
    bit closes[$];
    n = stim_q.size();
    mark.delete(); closes.delete();
    for (int k = 0; k < n; k++) begin mark.push_back(1'b0); closes.push_back(1'b0); end
    i = 0;
    while (i < n) begin
      if (i + 1 < n && stim_q[i] == 8'h2F && stim_q[i+1] == 8'h2A) begin
        j = i + 2; found = 1'b0;
        while (j + 1 < n && !found) begin
          if (stim_q[j] == 8'h2A && stim_q[j+1] == 8'h2F) found = 1'b1;
          else j++;
        end
        if (found) begin
          for (int k = i; k <= j + 1; k++) mark[k] = 1'b1;
          closes[j+1] = 1'b1;
          i = j + 2;
        end else begin
          for (int k = i; k < n; k++) mark[k] = 1'b1;
          i = n;
        end
      end else if (i + 1 < n && stim_q[i] == 8'h2F && stim_q[i+1] == 8'h2F) begin
        j = i + 2;
        while (j < n && stim_q[j] != 8'h0A) j++;
        if (j < n) begin
          for (int k = i; k <= j; k++) mark[k] = 1'b1;
          closes[j] = 1'b1;
          i = j + 1;
        end else begin
          for (int k = i; k < n; k++) mark[k] = 1'b1;
          i = n;
        end
      end else begin
        i++;
      end
    end
    exp_q.delete(); exp_cmt_q.delete(); exp_cnt_q.delete();
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (closes[k] && cnt < 255) cnt++;
      if (mark[k]) exp_q.push_back(8'h20);
      else if (stim_q[k] == 8'h0A || stim_q[k] == 8'h0D) exp_q.push_back(8'h20);
      else exp_q.push_back(stim_q[k]);
      exp_cmt_q.push_back(mark[k]);
      exp_cnt_q.push_back(cnt[7:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic load_str(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  function automatic string got_str();
    string s;
    s = "";
    foreach (got_q[i]) s = {s, $sformatf("%c", got_q[i])};
    return s;
  endfunction

  // Resets the DUT, streams stim_q plus one trailing space (lookahead for
  // the last real byte), and scores every decided byte against the model.
  task automatic run_stream();
    @(negedge clk);
    reset  = 1'b1;
    bus.in = 8'h2F;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    stim_q.push_back(8'h20);
    build_model();
    got_q.delete();
    cmt_seen = 0;
    for (int k = 0; k < stim_q.size(); k++) begin
      bus.in = stim_q[k];
      @(posedge clk); #1;
      if (k == 0) begin
        n_checks++;
        if (bus.out !== 8'h20 || bus.in_cmt !== 1'b0 || bus.cmt_cnt !== 8'd0)
          $display("FAIL first_after_reset: out=%h in_cmt=%b cnt=%0d, required out=20 in_cmt=0 cnt=0",
                   bus.out, bus.in_cmt, bus.cmt_cnt);
        else n_pass++;
      end else begin
        n_checks++;
        if (bus.out !== exp_q[k-1] || bus.in_cmt !== exp_cmt_q[k-1] || bus.cmt_cnt !== exp_cnt_q[k-1])
          $display("FAIL stream_byte[%0d]: out=%h in_cmt=%b cnt=%0d, required out=%h in_cmt=%b cnt=%0d",
                   k-1, bus.out, bus.in_cmt, bus.cmt_cnt, exp_q[k-1], exp_cmt_q[k-1], exp_cnt_q[k-1]);
        else n_pass++;
        got_q.push_back(bus.out);
        if (bus.in_cmt === 1'b1) cmt_seen++;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset  = 1'b1;
    bus.in = 8'h2A;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out !== 8'h20 || bus.in_cmt !== 1'b0 || bus.cmt_cnt !== 8'd0 || bus.dbg_state !== CODE)
      $display("FAIL reset_values: out=%h in_cmt=%b cnt=%0d state=%0d, required 20/0/0/CODE",
               bus.out, bus.in_cmt, bus.cmt_cnt, bus.dbg_state);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_plain_code();
    load_str("int a;");
    run_stream();
    n_checks++;
    if (got_str() != "int a;" || cmt_seen != 0 || bus.cmt_cnt !== 8'd0)
      $display("FAIL plain_code: got '%s' in_cmt_cycles=%0d cnt=%0d, required 'int a;' 0 0",
               got_str(), cmt_seen, bus.cmt_cnt);
    else n_pass++;
  endtask

  task automatic test_block_comment();
    load_str("int/*x*/a;");
    run_stream();
    n_checks++;
    if (got_str() != "int     a;" || cmt_seen != 5 || bus.cmt_cnt !== 8'd1)
      $display("FAIL block_comment: got '%s' in_cmt_cycles=%0d cnt=%0d, required 'int     a;' 5 1",
               got_str(), cmt_seen, bus.cmt_cnt);
    else n_pass++;
  endtask

  task automatic test_line_comment();
    load_str("a//b;");
    stim_q.push_back(8'h0A);
    stim_q.push_back(8'h63);
    run_stream();
    n_checks++;
    if (got_str() != "a     c" || bus.cmt_cnt !== 8'd1)
      $display("FAIL line_comment: got '%s' cnt=%0d, required 'a     c' 1", got_str(), bus.cmt_cnt);
    else n_pass++;
  endtask

  task automatic test_no_early_close();
    load_str("/*/x*/;");
    run_stream();
    n_checks++;
    if (got_str() != "      ;" || bus.cmt_cnt !== 8'd1)
      $display("FAIL no_early_close: got '%s' cnt=%0d, required '      ;' 1", got_str(), bus.cmt_cnt);
    else n_pass++;
  endtask

  task automatic test_lone_slash_cr();
    load_str("a/b");
    stim_q.push_back(8'h0D);
    run_stream();
    n_checks++;
    if (got_str() != "a/b " || bus.cmt_cnt !== 8'd0)
      $display("FAIL lone_slash_cr: got '%s' cnt=%0d, required 'a/b ' 0", got_str(), bus.cmt_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    load_str("/**//**/;");
    run_stream();
    n_checks++;
    if (got_str() != "        ;" || bus.cmt_cnt !== 8'd2)
      $display("FAIL back_to_back: got '%s' cnt=%0d, required '        ;' 2", got_str(), bus.cmt_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_comment();
    load_str("/*ab");
    run_stream();
    n_checks++;
    if (bus.dbg_state !== BLK || bus.in_cmt !== 1'b1)
      $display("FAIL in_blk_before_reset: state=%0d in_cmt=%b, required BLK 1", bus.dbg_state, bus.in_cmt);
    else n_pass++;
    load_str("x;");
    run_stream();
    n_checks++;
    if (got_str() != "x;" || bus.cmt_cnt !== 8'd0)
      $display("FAIL reset_mid_comment: got '%s' cnt=%0d, required 'x;' 0", got_str(), bus.cmt_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    stim_q.delete();
    for (int i = 0; i < 256; i++) begin
      stim_q.push_back(8'h2F); stim_q.push_back(8'h2A);
      stim_q.push_back(8'h2A); stim_q.push_back(8'h2F);
    end
    run_stream();
    n_checks++;
    if (bus.cmt_cnt !== 8'd255)
      $display("FAIL saturation: cnt=%0d, required 255", bus.cmt_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] alpha[10];
    alpha = '{8'h2F, 8'h2F, 8'h2A, 8'h0A, 8'h0D, 8'h61, 8'h3B, 8'h20, 8'h09, 8'hC3};
    for (int t = 0; t < 25; t++) begin
      stim_q.delete();
      for (int i = 0; i < 40; i++) stim_q.push_back(alpha[$urandom_range(0, 9)]);
      run_stream();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset  = 1'b1;
    bus.in = 8'h20;
    test_reset();
    test_plain_code();
    test_block_comment();
    test_line_comment();
    test_no_early_close();
    test_lone_slash_cr();
    test_back_to_back();
    test_reset_mid_comment();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
